// File: rtl/seg7_pkg.sv
// Shared constants, FSM states and helpers for the signed seven-segment scan driver.
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  // Largest magnitude that fits in the given number of decimal digits.
  function automatic int unsigned max_disp(input int digits);
    int unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift/add-3 step per clock after start.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin,
  output logic [4*(DIGITS+1)-1:0]   bcd,
  output logic                      done
);
  localparam int BW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_bcd;
  logic [BW-1:0]    w_adj;
  logic [CW-1:0]    r_cnt;

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k <= DIGITS; k++)
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_cnt <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_bin <= {r_bin[WIDTH-2:0], 1'b0};
      r_bcd <= {w_adj[BW-2:0], r_bin[WIDTH-1]};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bcd  = r_bcd;
  // High while the final iteration is pending, so the caller can step its FSM in lockstep.
  assign done = (r_cnt == CW'(1));
endmodule

// File: rtl/signed_7seg_scan.sv
// Signed/unsigned binary to multiplexed active-low seven-segment driver with
// atomic display commit, leading-zero blanking and overflow dashes.
module signed_7seg_scan
  import seg7_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              signed_mode,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg_n,
  output logic [DIGITS-1:0] an_n,
  output logic              neg_n
);
  localparam int          BW   = 4 * (DIGITS + 1);
  localparam int unsigned MAXV = max_disp(DIGITS);
  localparam int          PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int          IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                 r_state, w_state_nxt;
  logic                   w_accept, w_neg_in, w_done;
  logic [WIDTH-1:0]       w_mag;
  logic [BW-1:0]          w_bcd;
  logic                   r_neg_cap, r_ovf_cap;
  logic [DIGITS-1:0][3:0] r_dig;
  logic                   r_neg, r_ovf;
  logic [PW-1:0]          r_pre;
  logic [IW-1:0]          r_idx;
  logic [DIGITS-1:0]      w_hz;
  logic [6:0]             w_seg, r_seg;
  logic [DIGITS-1:0]      w_an, r_an;
  logic                   r_neg_n;

  assign w_neg_in = signed_mode & value[WIDTH-1];
  assign w_mag    = w_neg_in ? WIDTH'(~value + 1'b1) : value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE:    if (load) begin w_accept = 1'b1; w_state_nxt = CONVERT; end
      CONVERT: if (w_done) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_b2b (
    .clk(clk), .reset(reset), .start(w_accept), .bin(w_mag), .bcd(w_bcd), .done(w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_neg_cap <= 1'b0;
      r_ovf_cap <= 1'b0;
      r_dig     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_neg_cap <= w_neg_in;
        r_ovf_cap <= (32'(w_mag) > MAXV);
      end
      // Single-cycle commit so the scan never sees a partial result.
      if (r_state == COMMIT) begin
        for (int i = 0; i < DIGITS; i++) r_dig[i] <= w_bcd[4*i +: 4];
        r_neg <= r_neg_cap;
        r_ovf <= r_ovf_cap | (w_bcd[BW-1 -: 4] != 4'd0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PW'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // w_hz[i]: digit i and everything above it are zero.
  always_comb begin
    w_hz = '0;
    w_hz[DIGITS-1] = (r_dig[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) w_hz[i] = w_hz[i+1] && (r_dig[i] == 4'd0);
  end

  always_comb begin
    w_seg = seg_decode(r_dig[r_idx]);
    if (r_ovf) w_seg = SEG_DASH;
    else if ((BLANK_LZ != 0) && (r_idx != '0) && w_hz[r_idx]) w_seg = SEG_BLANK;
    for (int i = 0; i < DIGITS; i++) w_an[i] = (r_idx != IW'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg   <= SEG_BLANK;
      r_an    <= '1;
      r_neg_n <= 1'b1;
    end else begin
      r_seg   <= w_seg;
      r_an    <= w_an;
      r_neg_n <= ~r_neg;
    end
  end

  assign busy     = (r_state != IDLE);
  assign overflow = r_ovf;
  assign seg_n    = r_seg;
  assign an_n     = r_an;
  assign neg_n    = r_neg_n;
endmodule

// File: tb/tb_signed_7seg_scan.sv
// Randomized bench for signed_7seg_scan: an 8-bit and a 12-bit instance checked
// against an arithmetic model of the expected display.
module tb_signed_7seg_scan;
  localparam int SD = 4;
  localparam int D  = 3;
  localparam logic [6:0] SEGT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic clk = 1'b0;
  logic rst;
  logic sm;
  logic [7:0]  v8;
  logic [11:0] v12;
  logic ld8, ld12;
  logic b8, o8, n8, b12, o12, n12;
  logic [6:0] s8, s12;
  logic [D-1:0] a8, a12;
  logic sel;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  signed_7seg_scan #(.WIDTH(8), .DIGITS(D), .SCAN_DIV(SD), .BLANK_LZ(1)) u_dut8 (
    .clk(clk), .reset(rst), .value(v8), .signed_mode(sm), .load(ld8),
    .busy(b8), .overflow(o8), .seg_n(s8), .an_n(a8), .neg_n(n8));

  signed_7seg_scan #(.WIDTH(12), .DIGITS(D), .SCAN_DIV(SD), .BLANK_LZ(1)) u_dut12 (
    .clk(clk), .reset(rst), .value(v12), .signed_mode(sm), .load(ld12),
    .busy(b12), .overflow(o12), .seg_n(s12), .an_n(a12), .neg_n(n12));

  wire         w_busy = sel ? b12 : b8;
  wire         w_ovf  = sel ? o12 : o8;
  wire [6:0]   w_seg  = sel ? s12 : s8;
  wire [D-1:0] w_an   = sel ? a12 : a8;
  wire         w_neg  = sel ? n12 : n8;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int p10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int ref_seg(input int mag, input int i);
    if (mag > p10(D) - 1) return 'h3F;
    if (i > 0 && mag < p10(i)) return 'h7F;
    return int'(SEGT[(mag / p10(i)) % 10]);
  endfunction

  task automatic set_in(input bit is12, input bit l, input int val, input bit smode);
    sm = smode;
    if (is12) begin ld12 = l; v12 = 12'(val); end
    else      begin ld8  = l; v8  = 8'(val);  end
  endtask

  // Loads val, optionally fires an extra (ignored) load at busy cycle inj, checks busy length.
  task automatic do_load(input string tag, input bit is12, input int val, input bit smode, input int inj);
    int n;
    sel = is12;
    @(negedge clk);
    set_in(is12, 1'b1, val, smode);
    @(posedge clk); #1;
    set_in(is12, 1'b0, val, smode);
    n = 0;
    while (w_busy && n < 40) begin
      n++;
      if (n == inj) set_in(is12, 1'b1, 5, 1'b0);
      @(posedge clk); #1;
      set_in(is12, 1'b0, (n == inj) ? 5 : val, (n == inj) ? 1'b0 : smode);
    end
    chk({tag, "/busy_len"}, n, (is12 ? 12 : 8) + 1);
  endtask

  task automatic scan_check(input string tag, input int mag, input bit neg);
    bit [D-1:0] seen;
    int k, z;
    seen = '0;
    for (int c = 0; c < D * SD; c++) begin
      @(posedge clk); #1;
      k = -1; z = 0;
      for (int j = 0; j < D; j++) if (!w_an[j]) begin z++; k = j; end
      chk({tag, "/an_onehot"}, z, 1);
      if (k >= 0) begin
        seen[k] = 1'b1;
        chk({tag, "/seg"}, int'(w_seg), ref_seg(mag, k));
      end
      chk({tag, "/neg_n"}, int'(w_neg), (neg && mag != 0) ? 0 : 1);
      chk({tag, "/ovf"}, int'(w_ovf), (mag > p10(D) - 1) ? 1 : 0);
    end
    chk({tag, "/all_digits"}, int'(seen), (1 << D) - 1);
  endtask

  task automatic load_and_check(input string tag, input bit is12, input int val, input bit smode, input int inj);
    int w, mag;
    bit neg;
    w = is12 ? 12 : 8;
    neg = smode && (val >= (1 << (w - 1)));
    mag = neg ? (1 << w) - val : val;
    do_load(tag, is12, val, smode, inj);
    scan_check(tag, mag, neg);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D-1:0] ea;
    int idx, rv;
    bit rs;
    rst = 1'b1; sm = 1'b0; v8 = '0; v12 = '0; ld8 = 1'b0; ld12 = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/busy", int'(b8), 0);
    chk("rst/ovf", int'(o8), 0);
    chk("rst/seg", int'(s8), 'h7F);
    chk("rst/an", int'(a8), 'h7);
    chk("rst/neg", int'(n8), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3 * D * SD / 2; c++) begin
      @(posedge clk); #1;
      idx = (c / SD) % D;
      ea = ~(D'(1) << idx);
      chk("cad/an", int'(a8), int'(ea));
      chk("cad/seg", int'(s8), (idx == 0) ? 'h40 : 'h7F);
      chk("cad/neg", int'(n8), 1);
    end

    load_and_check("m128", 1'b0, 'h80, 1'b1, 0);
    load_and_check("u255", 1'b0, 'hFF, 1'b0, 0);
    load_and_check("m1_ign", 1'b0, 'hFF, 1'b1, 3);
    for (int t = 0; t < 10; t++) begin
      rv = int'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      load_and_check("rnd8", 1'b0, rv, rs, 0);
    end

    load_and_check("u1000", 1'b1, 1000, 1'b0, 0);
    load_and_check("u999", 1'b1, 999, 1'b0, 0);
    for (int t = 0; t < 6; t++) begin
      rv = int'($urandom_range(0, 4095));
      rs = 1'($urandom_range(0, 1));
      load_and_check("rnd12", 1'b1, rv, rs, 0);
    end

    // Abort a conversion of -128 with a reset pulse.
    sel = 1'b0;
    @(negedge clk);
    set_in(1'b0, 1'b1, 'h80, 1'b1);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 'h80, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort/busy", int'(b8), 0);
    chk("abort/ovf", int'(o8), 0);
    chk("abort/seg", int'(s8), 'h7F);
    chk("abort/an", int'(a8), 'h7);
    chk("abort/neg", int'(n8), 1);
    @(negedge clk);
    rst = 1'b0;
    scan_check("abort/disp", 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
